// File: rtl/tour_cmd_seq.sv
// tour_cmd_seq: arbitrates the motion-controller command port between the
// UART host path (IDLE pass-through) and knight's-tour replay. Each solved
// move is issued as a vertical leg followed by a horizontal leg, and each leg
// waits for cmd_done before the sequencer moves on.
// Optional feature macro: TOUR_CMD_FANFARE_EN makes horizontal legs use
// opcode 4'h3 instead of 4'h2.
module tour_cmd_seq #(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_tour,
  output logic [4:0]  mv_indx,
  input  logic [7:0]  move,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        cmd_done,
  output logic        send_resp,
  output logic        tour_busy,
  output logic        tour_err
);

  typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);
  localparam logic [3:0] V_OP     = 4'h2;
`ifdef TOUR_CMD_FANFARE_EN
  localparam logic [3:0] H_OP     = 4'h3;
`else
  localparam logic [3:0] H_OP     = 4'h2;
`endif
  localparam logic [7:0] HDG_N    = 8'h00;
  localparam logic [7:0] HDG_S    = 8'h7F;
  localparam logic [7:0] HDG_E    = 8'hBF;
  localparam logic [7:0] HDG_W    = 8'h3F;

  state_t      state, nxt;
  logic [4:0]  mv_nxt;
  logic        resp_q, resp_nxt;

  logic        v_north, h_east;
  logic [3:0]  v_sq, h_sq;
  logic [15:0] v_cmd, h_cmd;

  // Decode the one-hot move (lowest set bit wins) into leg directions/lengths.
  always_comb begin
    v_north = 1'b0;
    h_east  = 1'b0;
    v_sq    = 4'd0;
    h_sq    = 4'd0;
    casez (move)
      8'b???????1: begin v_north = 1'b1; v_sq = 4'd2; h_east = 1'b0; h_sq = 4'd1; end
      8'b??????10: begin v_north = 1'b1; v_sq = 4'd2; h_east = 1'b1; h_sq = 4'd1; end
      8'b?????100: begin v_north = 1'b1; v_sq = 4'd1; h_east = 1'b0; h_sq = 4'd2; end
      8'b????1000: begin v_north = 1'b0; v_sq = 4'd1; h_east = 1'b0; h_sq = 4'd2; end
      8'b???10000: begin v_north = 1'b0; v_sq = 4'd2; h_east = 1'b0; h_sq = 4'd1; end
      8'b??100000: begin v_north = 1'b0; v_sq = 4'd2; h_east = 1'b1; h_sq = 4'd1; end
      8'b?1000000: begin v_north = 1'b0; v_sq = 4'd1; h_east = 1'b1; h_sq = 4'd2; end
      8'b10000000: begin v_north = 1'b1; v_sq = 4'd1; h_east = 1'b1; h_sq = 4'd2; end
      default:     begin v_north = 1'b0; v_sq = 4'd0; h_east = 1'b0; h_sq = 4'd0; end
    endcase
  end

  assign v_cmd = {V_OP, (v_north ? HDG_N : HDG_S), v_sq};
  assign h_cmd = {H_OP, (h_east  ? HDG_E : HDG_W), h_sq};

  // Next-state and port muxing; IDLE is a transparent UART path.
  always_comb begin
    nxt              = state;
    mv_nxt           = mv_indx;
    resp_nxt         = 1'b0;
    cmd              = cmd_UART;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    send_resp        = 1'b0;
    tour_err         = 1'b0;
    case (state)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        // a tour start claims the port, so the UART command stays pending
        clr_cmd_rdy_UART = clr_cmd_rdy & ~start_tour;
        send_resp        = cmd_done | resp_q;
        if (start_tour) begin
          nxt    = VERT;
          mv_nxt = 5'd0;
        end
      end
      VERT: begin
        cmd = v_cmd;
        if (move == 8'h00) begin
          // no legal move: abort without offering a bogus command
          tour_err = 1'b1;
          nxt      = IDLE;
          mv_nxt   = 5'd0;
        end else begin
          cmd_rdy = 1'b1;
          if (clr_cmd_rdy) nxt = WAIT_V;
        end
      end
      WAIT_V: begin
        cmd = v_cmd;
        if (cmd_done) nxt = HORZ;
      end
      HORZ: begin
        cmd     = h_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) nxt = WAIT_H;
      end
      WAIT_H: begin
        cmd = h_cmd;
        if (cmd_done) begin
          if (mv_indx == LAST_IDX) begin
            nxt      = IDLE;
            mv_nxt   = 5'd0;
            resp_nxt = 1'b1;
          end else begin
            nxt    = VERT;
            mv_nxt = mv_indx + 5'd1;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // State, move index, completion pulse and busy flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mv_indx   <= 5'd0;
      resp_q    <= 1'b0;
      tour_busy <= 1'b0;
    end else begin
      state     <= nxt;
      mv_indx   <= mv_nxt;
      resp_q    <= resp_nxt;
      tour_busy <= (nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Directed bench for tour_cmd_seq: pass-through, full tours, arbitration,
// illegal-move abort and asynchronous reset mid-tour.
module tb_tour_cmd_seq;

`ifdef TOUR_CMD_FANFARE_EN
  localparam logic [3:0] HOP = 4'h3;
`else
  localparam logic [3:0] HOP = 4'h2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_tour;
  logic [4:0]  mv_indx;
  logic [7:0]  move;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        cmd_done;
  logic        send_resp;
  logic        tour_busy;
  logic        tour_err;

  logic [7:0]  move_mem [0:31];
  int          exp_b    [0:23];
  logic [15:0] exp_v    [0:7];
  logic [11:0] exp_h_lo [0:7];

  int tests = 0;
  int fails = 0;
  int cmd_cnt = 0;

  always #5 clk = ~clk;

  assign move = move_mem[mv_indx];

  tour_cmd_seq #(.NUM_MOVES(24)) dut (
    .clk(clk), .rst(rst), .start_tour(start_tour), .mv_indx(mv_indx),
    .move(move), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
    .clr_cmd_rdy_UART(clr_cmd_rdy_UART), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .cmd_done(cmd_done), .send_resp(send_resp),
    .tour_busy(tour_busy), .tour_err(tour_err)
  );

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Called at negedge+1 with the DUT in VERT for move 0.
  // mode 0: complete tour; 1: expect abort at index stop; 2: reset in WAIT_H at stop.
  task automatic run_tour(input int stop, input int mode);
    for (int i = 0; i < 24; i++) begin
      int b;
      b = exp_b[i];
      if (mode == 1 && i == stop) begin
        chk1("err_pulse", tour_err, 1'b1);
        chk16("err_idx", 16'(mv_indx), 16'(i));
        @(negedge clk); #1;
        chk1("err_once", tour_err, 1'b0);
        chk1("err_busy", tour_busy, 1'b0);
        chk1("err_noresp", send_resp, 1'b0);
        @(negedge clk); #1;
        chk1("err_noresp2", send_resp, 1'b0);
        chk1("err_idle_err", tour_err, 1'b0);
        return;
      end
      chk16("vert_cmd", cmd, exp_v[b]);
      chk1("vert_rdy", cmd_rdy, 1'b1);
      chk16("vert_idx", 16'(mv_indx), 16'(i));
      chk1("vert_busy", tour_busy, 1'b1);
      chk1("vert_err", tour_err, 1'b0);
      if (i == 0) begin
        // cmd_done in VERT must not advance the sequencer
        cmd_done = 1'b1;
        @(negedge clk); cmd_done = 1'b0; #1;
        chk1("vert_hold_rdy", cmd_rdy, 1'b1);
        chk16("vert_hold_cmd", cmd, exp_v[b]);
      end
      clr_cmd_rdy = 1'b1; #1;
      chk1("vert_clr_uart", clr_cmd_rdy_UART, 1'b0);
      @(negedge clk); clr_cmd_rdy = 1'b0; cmd_done = 1'b1;
      if (i == 2) start_tour = 1'b1;
      #1;
      chk1("waitv_rdy", cmd_rdy, 1'b0);
      cmd_cnt++;
      @(negedge clk); cmd_done = 1'b0; start_tour = 1'b0; #1;
      chk16("horz_cmd", cmd, {HOP, exp_h_lo[b]});
      chk1("horz_rdy", cmd_rdy, 1'b1);
      chk16("horz_idx", 16'(mv_indx), 16'(i));
      chk1("horz_resp", send_resp, 1'b0);
      clr_cmd_rdy = 1'b1; #1;
      chk1("horz_clr_uart", clr_cmd_rdy_UART, 1'b0);
      @(negedge clk); clr_cmd_rdy = 1'b0; #1;
      chk1("waith_rdy", cmd_rdy, 1'b0);
      cmd_cnt++;
      if (mode == 2 && i == stop) begin
        #1 rst = 1'b1;
        #1;
        chk16("rst_idx", 16'(mv_indx), 16'd0);
        chk1("rst_busy", tour_busy, 1'b0);
        @(negedge clk); rst = 1'b0; #1;
        return;
      end
      cmd_done = 1'b1;
      @(negedge clk); cmd_done = 1'b0; #1;
    end
  endtask

  initial begin
    rst = 1'b1; start_tour = 1'b0; cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b0; cmd_done = 1'b0;

    // Hand-derived leg commands per lowest set bit (horizontal opcode added later)
    exp_v[0] = 16'h2002; exp_h_lo[0] = 12'h3F1;
    exp_v[1] = 16'h2002; exp_h_lo[1] = 12'hBF1;
    exp_v[2] = 16'h2001; exp_h_lo[2] = 12'h3F2;
    exp_v[3] = 16'h27F1; exp_h_lo[3] = 12'h3F2;
    exp_v[4] = 16'h27F2; exp_h_lo[4] = 12'h3F1;
    exp_v[5] = 16'h27F2; exp_h_lo[5] = 12'hBF1;
    exp_v[6] = 16'h27F1; exp_h_lo[6] = 12'hBF2;
    exp_v[7] = 16'h2001; exp_h_lo[7] = 12'hBF2;

    // Move 0 is the single 8'h80 case; later moves add extra higher bits.
    for (int i = 0; i < 32; i++) move_mem[i] = 8'h01;
    for (int i = 0; i < 24; i++) begin
      logic [7:0] one;
      exp_b[i] = (i + 7) % 8;
      one = 8'h01 << exp_b[i];
      if (i < 8)       move_mem[i] = one;
      else if (i < 16) move_mem[i] = 8'hFF << exp_b[i];
      else             move_mem[i] = one | 8'h80;
    end

    // Reset values
    #12;
    chk16("rst_mv_indx", 16'(mv_indx), 16'd0);
    chk1("rst_tour_busy", tour_busy, 1'b0);
    chk1("rst_tour_err", tour_err, 1'b0);
    chk1("rst_send_resp", send_resp, 1'b0);
    chk1("rst_cmd_rdy", cmd_rdy, 1'b0);
    @(negedge clk); rst = 1'b0; #1;

    // UART pass-through
    @(negedge clk); cmd_UART = 16'h2BF1; cmd_rdy_UART = 1'b1; #1;
    chk16("pt_cmd", cmd, 16'h2BF1);
    chk1("pt_rdy", cmd_rdy, 1'b1);
    chk1("pt_clr0", clr_cmd_rdy_UART, 1'b0);
    clr_cmd_rdy = 1'b1; #1;
    chk1("pt_clr1", clr_cmd_rdy_UART, 1'b1);
    @(negedge clk); clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0; cmd_done = 1'b1; #1;
    chk1("pt_resp", send_resp, 1'b1);
    chk1("pt_busy", tour_busy, 1'b0);
    @(negedge clk); cmd_done = 1'b0; #1;
    chk1("pt_resp_off", send_resp, 1'b0);

    // Full tour with a UART command held pending; start collides with it
    @(negedge clk); cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1; start_tour = 1'b1; clr_cmd_rdy = 1'b1; #1;
    chk1("coll_clr_uart", clr_cmd_rdy_UART, 1'b0);
    @(negedge clk); start_tour = 1'b0; clr_cmd_rdy = 1'b0; #1;
    cmd_cnt = 0;
    run_tour(0, 0);
    chk1("t1_resp", send_resp, 1'b1);
    chk1("t1_busy", tour_busy, 1'b0);
    chk16("t1_idx", 16'(mv_indx), 16'd0);
    chk16("t1_cmd_uart", cmd, 16'h1234);
    chk1("t1_rdy_uart", cmd_rdy, 1'b1);
    chk16("t1_cmd_cnt", 16'(cmd_cnt), 16'd48);
    @(negedge clk); #1;
    chk1("t1_resp_once", send_resp, 1'b0);
    cmd_rdy_UART = 1'b0;

    // Illegal move at index 5
    move_mem[5] = 8'h00;
    @(negedge clk); start_tour = 1'b1;
    @(negedge clk); start_tour = 1'b0; #1;
    run_tour(5, 2 - 1);
    move_mem[5] = 8'h04 << 0;
    move_mem[5] = 8'h01 << exp_b[5];

    // Reset in WAIT_H at index 10, then a clean restart from index 0
    @(negedge clk); start_tour = 1'b1;
    @(negedge clk); start_tour = 1'b0; #1;
    run_tour(10, 2);
    @(negedge clk); start_tour = 1'b1;
    @(negedge clk); start_tour = 1'b0; #1;
    chk16("restart_idx", 16'(mv_indx), 16'd0);
    run_tour(0, 0);
    chk1("t3_resp", send_resp, 1'b1);
    chk1("t3_busy", tour_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tour_cmd_seq.md
# tour_cmd_seq

Sequencer between the knight's-tour solver, the UART command path and the motion controller. In idle it passes host (UART) commands through to the motion controller unchanged. When the solver reports a solution, it takes over the command port and reads the 24 solved moves by index. It turns each move into two motion commands, a vertical leg and then a horizontal leg, and paces them against motion-complete handshakes.

## Interface
Parameters:
- NUM_MOVES, 24, number of moves replayed per tour; mv_indx is 5 bits, so NUM_MOVES must be 1–32.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_tour  in  1  one-cycle pulse from the solver (its done); solution is valid.
- mv_indx  out  5  index of the move being read; drives the solver's read index.
- move  in  8  one-hot move returned for mv_indx (combinational from the solver).
- cmd_UART  in  16  command from the UART wrapper.
- cmd_rdy_UART  in  1  cmd_UART is valid.
- clr_cmd_rdy_UART  out  1  acknowledges cmd_UART.
- cmd  out  16  command to the motion controller: [15:12] opcode, [11:4] heading, [3:0] squares.
- cmd_rdy  out  1  cmd is valid.
- clr_cmd_rdy  in  1  motion controller accepts cmd.
- cmd_done  in  1  one-cycle pulse: the motion controller finished the current command.
- send_resp  out  1  one-cycle pulse asking the UART to send an acknowledge to the host.
- tour_busy  out  1  high while the tour owns the command port.
- tour_err  out  1  one-cycle pulse when a tour is aborted on an illegal move.

## Operation
States: IDLE, VERT, WAIT_V, HORZ, WAIT_H.

- **IDLE (UART pass-through):**
  - cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy, send_resp=cmd_done.
  - start_tour → VERT, mv_indx←0.
- **VERT:**
  - Present the vertical leg with cmd_rdy=1.
  - clr_cmd_rdy → WAIT_V.
  - move==8'h00 → IDLE and pulse tour_err.
- **WAIT_V:** cmd_done → HORZ.
- **HORZ:**
  - Present the horizontal leg with cmd_rdy=1.
  - clr_cmd_rdy → WAIT_H.
- **WAIT_H:** on cmd_done:
  - If mv_indx==NUM_MOVES-1 → IDLE, pulse send_resp, mv_indx←0.
  - Otherwise mv_indx←mv_indx+1 → VERT.

Move decode:
- Use the lowest set bit; any other set bits are ignored.
- +y is north, +x is east.
- Bit mapping, as (dx, dy): bit0 (-1,+2), bit1 (+1,+2), bit2 (-2,+1), bit3 (-2,-1), bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1).
- Vertical leg: opcode 4'h2, heading 8'h00 (north) if dy>0 else 8'h7F (south), squares=|dy|.
- Horizontal leg: opcode per Configuration, heading 8'hBF (east) if dx>0 else 8'h3F (west), squares=|dx|.

Arbitration during a tour:
- cmd_rdy_UART is ignored and clr_cmd_rdy_UART is held at 0. A pending UART command stays pending until IDLE is re-entered.
- start_tour while not in IDLE is ignored.
- send_resp is suppressed except for the final completion.

## Timing
Reset values: state=IDLE, mv_indx=0, tour_busy=0, tour_err=0, send_resp=0, cmd_rdy=0 (cmd_rdy and send_resp then follow the IDLE pass-through once cmd_rdy_UART / cmd_done are active). Reset mid-tour returns to IDLE immediately, asynchronously.

Cycle behaviour:
- start_tour high at edge N → VERT from N+1, with tour_busy=1 and cmd_rdy=1 in the same cycle.
- cmd is combinational from move and state; move must be valid in the same cycle as mv_indx.
- clr_cmd_rdy sampled high at an edge → cmd_rdy=0 from the next cycle.
- cmd_done is honoured only in WAIT_V/WAIT_H; it is ignored in VERT/HORZ.
- Final cmd_done at edge M → send_resp=1 for exactly cycle M+1, and tour_busy=0 from M+1.
- Simultaneous start_tour and cmd_rdy_UART in IDLE: the tour wins, and clr_cmd_rdy_UART is not asserted.
- tour_busy is registered: 1 in every non-IDLE state.

## Configuration
- TOUR_CMD_FANFARE_EN defined: horizontal legs use opcode 4'h3 (move with fanfare).
- TOUR_CMD_FANFARE_EN undefined: horizontal legs use opcode 4'h2. All other behaviour is identical.

## Test plan
- UART pass-through in IDLE:
  - Stimulus: cmd_UART=16'h2BF1 with cmd_rdy_UART=1, then clr_cmd_rdy=1, then cmd_done pulse.
  - Required: cmd=16'h2BF1 and cmd_rdy=1 the same cycle; clr_cmd_rdy_UART mirrors clr_cmd_rdy; send_resp=1 the cycle of cmd_done.
- Single move decode:
  - Stimulus: start_tour, move=8'h80.
  - Required: VERT presents cmd=16'h2001. After accept and cmd_done, HORZ presents 16'h3BF2 (macro on) or 16'h2BF2 (macro off).
- Full tour of 24 moves with ideal handshakes:
  - Required: 48 commands, mv_indx runs 0→23, one send_resp after the 48th cmd_done, tour_busy low on the next cycle.
- Arbitration:
  - Stimulus: cmd_rdy_UART=1 held through a tour.
  - Required: clr_cmd_rdy_UART stays 0 throughout; after return to IDLE, cmd equals cmd_UART.
- Illegal move:
  - Stimulus: move=8'h00 at mv_indx=5.
  - Required: tour_err pulses once, state returns to IDLE, and no send_resp.
- Reset mid-tour:
  - Stimulus: rst asserted in WAIT_H at mv_indx=10.
  - Required: immediately mv_indx=0 and tour_busy=0; the next start_tour restarts at index 0.
